// File: rtl/forward_unit_pkg.sv
// Shared RV32I opcode constants and forwarding select codes.
// Used by the EX-stage forwarding unit and its data mux.
package forward_unit_pkg;

    localparam logic [6:0] OPCODE_LOAD        = 7'b0000011;
    localparam logic [6:0] OPCODE_ITYPE       = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC       = 7'b0010111;
    localparam logic [6:0] OPCODE_RTYPE       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI         = 7'b0110111;
    localparam logic [6:0] OPCODE_JALR        = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL         = 7'b1101111;
    localparam logic [6:0] OPCODE_ENVIRONMENT = 7'b1110011;

    localparam logic [1:0] FWD_SEL_REGFILE = 2'b01;
    localparam logic [1:0] FWD_SEL_MEM     = 2'b10;

endpackage

// File: rtl/forward_unit_if.sv
// Bundles the hazard flags, MEM-stage results and forwarding outputs.
// master drives hazard/MEM values; slave is the forwarding unit.
interface forward_unit_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic [1:0]       hazard_op;
    logic [6:0]       MEM_opcode;
    logic [XLEN-1:0]  MEM_imm;
    logic [XLEN-1:0]  MEM_alu_result;
    logic [XLEN-1:0]  MEM_csr_read_data;
    logic [XLEN-1:0]  MEM_byte_enable_logic_register_file_write_data;
    logic [XLEN-1:0]  MEM_pc_plus_4;
    logic [XLEN-1:0]  alu_forward_source_data_a;
    logic [XLEN-1:0]  alu_forward_source_data_b;
    logic [1:0]       alu_forward_source_select_a;
    logic [1:0]       alu_forward_source_select_b;
    logic [CNT_W-1:0] forward_count_a;
    logic [CNT_W-1:0] forward_count_b;

    modport master (
        output hazard_op, MEM_opcode, MEM_imm, MEM_alu_result, MEM_csr_read_data,
               MEM_byte_enable_logic_register_file_write_data, MEM_pc_plus_4,
        input  alu_forward_source_data_a, alu_forward_source_data_b,
               alu_forward_source_select_a, alu_forward_source_select_b,
               forward_count_a, forward_count_b
    );

    modport slave (
        input  hazard_op, MEM_opcode, MEM_imm, MEM_alu_result, MEM_csr_read_data,
               MEM_byte_enable_logic_register_file_write_data, MEM_pc_plus_4,
        output alu_forward_source_data_a, alu_forward_source_data_b,
               alu_forward_source_select_a, alu_forward_source_select_b,
               forward_count_a, forward_count_b
    );
endinterface

// File: rtl/forward_unit_data_mux.sv
// Picks the value the MEM-stage instruction will write back, by opcode.
// Unrecognised opcodes fall through to the ALU result.
module forward_data_mux
    import forward_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [6:0]      i_opcode,
    input  logic [XLEN-1:0] i_imm,
    input  logic [XLEN-1:0] i_alu_result,
    input  logic [XLEN-1:0] i_csr_read_data,
    input  logic [XLEN-1:0] i_load_data,
    input  logic [XLEN-1:0] i_pc_plus_4,
    output logic [XLEN-1:0] o_fwd_data
);

    always_comb begin
        o_fwd_data = i_alu_result;
        case (i_opcode)
            OPCODE_LOAD:              o_fwd_data = i_load_data;
            OPCODE_JAL, OPCODE_JALR:  o_fwd_data = i_pc_plus_4;
            OPCODE_LUI:               o_fwd_data = i_imm;
            OPCODE_ENVIRONMENT:       o_fwd_data = i_csr_read_data;
            default:                  o_fwd_data = i_alu_result;
        endcase
    end

endmodule

// File: rtl/forward_unit.sv
// EX-stage operand forwarding: per-operand gating of the MEM forward value
// plus two saturating forwarding-event counters.
module forward_unit
    import forward_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    forward_unit_if.slave bus
);

    logic [XLEN-1:0]  w_fwd_data;
    logic [CNT_W-1:0] r_cnt_a;
    logic [CNT_W-1:0] r_cnt_b;

    forward_data_mux #(.XLEN(XLEN)) u_data_mux (
        .i_opcode        (bus.MEM_opcode),
        .i_imm           (bus.MEM_imm),
        .i_alu_result    (bus.MEM_alu_result),
        .i_csr_read_data (bus.MEM_csr_read_data),
        .i_load_data     (bus.MEM_byte_enable_logic_register_file_write_data),
        .i_pc_plus_4     (bus.MEM_pc_plus_4),
        .o_fwd_data      (w_fwd_data)
    );

    // Non-forwarded operands drive zero so the ALU mux sees a clean value.
    always_comb begin
        bus.alu_forward_source_select_a = FWD_SEL_REGFILE;
        bus.alu_forward_source_select_b = FWD_SEL_REGFILE;
        bus.alu_forward_source_data_a   = '0;
        bus.alu_forward_source_data_b   = '0;
        if (bus.hazard_op[0]) begin
            bus.alu_forward_source_select_a = FWD_SEL_MEM;
            bus.alu_forward_source_data_a   = w_fwd_data;
        end
        if (bus.hazard_op[1]) begin
            bus.alu_forward_source_select_b = FWD_SEL_MEM;
            bus.alu_forward_source_data_b   = w_fwd_data;
        end
    end

    // Counters hold at all-ones rather than wrap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt_a <= '0;
            r_cnt_b <= '0;
        end else begin
            if (bus.hazard_op[0] && (r_cnt_a != {CNT_W{1'b1}}))
                r_cnt_a <= r_cnt_a + {{(CNT_W-1){1'b0}}, 1'b1};
            if (bus.hazard_op[1] && (r_cnt_b != {CNT_W{1'b1}}))
                r_cnt_b <= r_cnt_b + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.forward_count_a = r_cnt_a;
    assign bus.forward_count_b = r_cnt_b;

endmodule

// File: tb/tb_forward_unit.sv
// Self-checking bench for forward_unit: directed vector table, randomized
// traffic against a behavioural model, counter saturation and reset pulse.
module tb_forward_unit;
    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    localparam logic [31:0] IMM = 32'hAAAA0000, ALU = 32'hDEADBEEF,
                            CSR = 32'hFACECAFE, LDD = 32'h11112222,
                            PC4 = 32'h00401004;

    logic clk;
    logic reset_n;
    int   n_cmp, n_bad;
    int   m_cnt_a, m_cnt_b;

    forward_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    forward_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  hz;
        logic [6:0]  op;
        logic [1:0]  sel_a;
        logic [1:0]  sel_b;
        logic [31:0] data_a;
        logic [31:0] data_b;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] ref_fwd(input logic [6:0] op, input logic [31:0] imm,
            input logic [31:0] alu, input logic [31:0] csr, input logic [31:0] ld,
            input logic [31:0] pc4);
        if (op == 7'h03) return ld;
        if (op == 7'h6F || op == 7'h67) return pc4;
        if (op == 7'h37) return imm;
        if (op == 7'h73) return csr;
        return alu;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cnt(input string name);
        chk({name, ".cnt_a"}, 64'(bus.forward_count_a), 64'(m_cnt_a));
        chk({name, ".cnt_b"}, 64'(bus.forward_count_b), 64'(m_cnt_b));
    endtask

    // One rising edge; model counters advance from the hazard bits seen at the edge.
    task automatic tick();
        logic [1:0] h;
        h = bus.hazard_op;
        @(posedge clk);
        if (reset_n) begin
            if (h[0] && m_cnt_a < CMAX) m_cnt_a++;
            if (h[1] && m_cnt_b < CMAX) m_cnt_b++;
        end
        #1;
    endtask

    task automatic set_data(input logic [31:0] imm, input logic [31:0] alu,
            input logic [31:0] csr, input logic [31:0] ld, input logic [31:0] pc4);
        bus.MEM_imm = imm;
        bus.MEM_alu_result = alu;
        bus.MEM_csr_read_data = csr;
        bus.MEM_byte_enable_logic_register_file_write_data = ld;
        bus.MEM_pc_plus_4 = pc4;
    endtask

    task automatic chk_outputs(input string name, input logic [31:0] fwd);
        chk({name, ".sel_a"}, 64'(bus.alu_forward_source_select_a),
            bus.hazard_op[0] ? 64'd2 : 64'd1);
        chk({name, ".sel_b"}, 64'(bus.alu_forward_source_select_b),
            bus.hazard_op[1] ? 64'd2 : 64'd1);
        chk({name, ".data_a"}, 64'(bus.alu_forward_source_data_a),
            bus.hazard_op[0] ? 64'(fwd) : 64'd0);
        chk({name, ".data_b"}, 64'(bus.alu_forward_source_data_b),
            bus.hazard_op[1] ? 64'(fwd) : 64'd0);
    endtask

    initial begin
        logic [31:0] r_imm, r_alu, r_csr, r_ld, r_pc4, exp_fwd;
        logic [6:0]  ops[8];
        n_cmp = 0; n_bad = 0; m_cnt_a = 0; m_cnt_b = 0;

        vecs[0] = '{"rtype_none", 2'b00, 7'b0110011, 2'b01, 2'b01, 32'h0, 32'h0};
        vecs[1] = '{"load_a",     2'b01, 7'b0000011, 2'b10, 2'b01, LDD,   32'h0};
        vecs[2] = '{"jalr_b",     2'b10, 7'b1100111, 2'b01, 2'b10, 32'h0, PC4};
        vecs[3] = '{"jal_b",      2'b10, 7'b1101111, 2'b01, 2'b10, 32'h0, PC4};
        vecs[4] = '{"lui_b",      2'b10, 7'b0110111, 2'b01, 2'b10, 32'h0, IMM};
        vecs[5] = '{"auipc_b",    2'b10, 7'b0010111, 2'b01, 2'b10, 32'h0, ALU};
        vecs[6] = '{"env_ab",     2'b11, 7'b1110011, 2'b10, 2'b10, CSR,   CSR};
        vecs[7] = '{"itype_ab",   2'b11, 7'b0010011, 2'b10, 2'b10, ALU,   ALU};
        vecs[8] = '{"unknown_a",  2'b01, 7'b1111111, 2'b10, 2'b01, ALU,   32'h0};
        vecs[9] = '{"rtype_ab",   2'b11, 7'b0110011, 2'b10, 2'b10, ALU,   ALU};

        ops = '{7'h03, 7'h6F, 7'h67, 7'h37, 7'h73, 7'h33, 7'h13, 7'h17};

        reset_n = 1'b0;
        bus.hazard_op = 2'b00;
        bus.MEM_opcode = 7'b0110011;
        set_data(IMM, ALU, CSR, LDD, PC4);
        #12;
        chk_cnt("reset");
        chk("reset.sel_a", 64'(bus.alu_forward_source_select_a), 64'd1);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus.hazard_op = vecs[i].hz;
            bus.MEM_opcode = vecs[i].op;
            #1;
            chk({vecs[i].name, ".sel_a"},  64'(bus.alu_forward_source_select_a), 64'(vecs[i].sel_a));
            chk({vecs[i].name, ".sel_b"},  64'(bus.alu_forward_source_select_b), 64'(vecs[i].sel_b));
            chk({vecs[i].name, ".data_a"}, 64'(bus.alu_forward_source_data_a),   64'(vecs[i].data_a));
            chk({vecs[i].name, ".data_b"}, 64'(bus.alu_forward_source_data_b),   64'(vecs[i].data_b));
            tick();
            chk_cnt(vecs[i].name);
        end

        for (int i = 0; i < 300; i++) begin
            r_imm = $urandom; r_alu = $urandom; r_csr = $urandom;
            r_ld = $urandom;  r_pc4 = $urandom;
            set_data(r_imm, r_alu, r_csr, r_ld, r_pc4);
            bus.hazard_op = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) bus.MEM_opcode = 7'($urandom_range(0, 127));
            else bus.MEM_opcode = ops[$urandom_range(0, 7)];
            #1;
            exp_fwd = ref_fwd(bus.MEM_opcode, r_imm, r_alu, r_csr, r_ld, r_pc4);
            chk_outputs("rand", exp_fwd);
            tick();
            chk_cnt("rand");
        end

        set_data(IMM, ALU, CSR, LDD, PC4);
        bus.MEM_opcode = 7'b1110011;
        bus.hazard_op = 2'b11;
        #1;
        for (int i = 0; i < CMAX + 4; i++) tick();
        chk("sat.cnt_a", 64'(bus.forward_count_a), 64'hFFFF);
        chk("sat.cnt_b", 64'(bus.forward_count_b), 64'hFFFF);
        tick();
        chk_cnt("sat_hold");

        reset_n = 1'b0;
        #2;
        m_cnt_a = 0; m_cnt_b = 0;
        chk_cnt("rst_pulse");
        chk_outputs("rst_pulse", CSR);
        reset_n = 1'b1;
        #1;
        tick();
        chk_cnt("after_rst");
        chk_outputs("after_rst", CSR);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
